// File: rtl/tap_arb_pkg.sv
// Shared types and helpers for the TAP result arbiter and related schedulers.
package tap_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int src_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, modulo NUM_REQ.
module rr_grant_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               grant_valid
);

  int unsigned idx;

  // Scan from ptr upward with wraparound; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant       = PTR_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tap_result_arbiter.sv
// Round-robin arbiter sharing the outbound byte channel to tap_encoder.
// Optional packet locking is enabled with the TAP_ARB_LOCK_EN macro.
module tap_result_arbiter
  import tap_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          tck,
  input  logic                          test_logic_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [src_width(NUM_REQ)-1:0] out_src
);

  localparam int SW = src_width(NUM_REQ);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [SW-1:0] pick_idx;
  logic          pick_valid;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          load_en;
  logic          accept;
  logic          ptr_adv;

  rr_grant_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (SW)
  ) u_picker (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (pick_idx),
    .grant_valid (pick_valid)
  );

  assign load_en  = !out_valid || out_ready;
  assign accept   = load_en && grant_valid;
  assign ptr_next = (grant == SW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef TAP_ARB_LOCK_EN
  logic [SW-1:0] lock_idx;

  // Remember which requester owns the channel while a packet is in flight.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      lock_idx <= '0;
    end else if (accept && state == ARB) begin
      lock_idx <= grant;
    end
  end

  // Next-state: lock on a non-final beat, release on the locked requester's final beat.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB:  if (accept && !req_last[grant]) state_next = LOCK;
      LOCK: if (accept &&  req_last[grant]) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Grant selection: picker in ARB, forced to the locked requester in LOCK.
  always_comb begin
    grant       = pick_idx;
    grant_valid = pick_valid;
    if (state == LOCK) begin
      grant       = lock_idx;
      grant_valid = req_valid[lock_idx];
    end
  end

  // Pointer moves only when a packet completes (single beat or the unlocking beat).
  assign ptr_adv = accept && req_last[grant];
`else
  logic unused_last;
  assign unused_last = ^req_last;

  // Without packet locking the machine never leaves ARB.
  always_comb begin
    state_next = ARB;
  end

  // Grant selection: picker output, gated by the (permanent) ARB state.
  always_comb begin
    grant       = pick_idx;
    grant_valid = pick_valid && (state == ARB);
  end

  assign ptr_adv = accept;
`endif

  // State register.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      state <= ARB;
    end else begin
      state <= state_next;
    end
  end

  // Ready is one-hot on the granted requester whenever the output register can load.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant == SW'(i));
    end
  end

  // One-deep output register and round-robin pointer.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_data  <= req_data[grant*DATA_WIDTH +: DATA_WIDTH];
        out_src   <= grant;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ptr_adv) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_tap_result_arbiter.sv
// Self-checking bench for tap_result_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_tap_result_arbiter;

  localparam int N = 4;
  localparam logic [31:0] D_BASE = 32'h13121110;

  logic        tck = 1'b0;
  logic        test_logic_reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_src;

  int checks = 0;
  int errors = 0;
  bit primed = 0;

  // Reference model state
  int   m_ptr;
  bit   m_valid;
  logic [7:0] m_data;
  int   m_src;
  bit   m_lock;
  int   m_lidx;

  tap_result_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (N)
  ) dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_src          (out_src)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index the spec's rules pick this cycle, or -1 when nothing is accepted.
  function automatic int m_grant();
    if (m_valid && !out_ready) return -1;
    if (m_lock) return req_valid[m_lidx] ? m_lidx : -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_lock = 0; m_lidx = 0;
  endtask

  task automatic model_step();
    int g;
    if (test_logic_reset) begin
      model_reset();
      return;
    end
    g = m_grant();
    if (g >= 0) begin
      m_data  = req_data[g*8 +: 8];
      m_src   = g;
      m_valid = 1;
`ifdef TAP_ARB_LOCK_EN
      if (!m_lock) begin
        if (!req_last[g]) begin m_lock = 1; m_lidx = g; end
        else m_ptr = (g + 1) % N;
      end else if (req_last[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
      end
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    int g;
    g = m_grant();
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
  endtask

  // Drive one cycle's inputs on the falling edge, check, then advance the model on the rising edge.
  task automatic cycle(input logic rst, input logic [3:0] v, input logic [3:0] last,
                       input logic ordy, input logic [31:0] data);
    @(negedge tck);
    test_logic_reset = rst;
    req_valid = v;
    req_last  = last;
    out_ready = ordy;
    req_data  = data;
    #1;
    if (primed) compare_all();
    @(posedge tck);
    model_step();
  endtask

  logic [31:0] d;
  int exp_lock [5];

  initial begin
    model_reset();

    // Reset then idle
    cycle(1, 4'b0000, 4'b1111, 0, D_BASE);
    primed = 1;
    cycle(1, 4'b0000, 4'b1111, 0, D_BASE);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ready", req_ready, 0);
    d = 32'h00A50000;
    cycle(0, 4'b0100, 4'b1111, 1, d);
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_src", out_src, 2);

    // Continuous streaming from all four requesters
    cycle(1, 4'b0000, 4'b1111, 1, D_BASE);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 4'b1111, 4'b1111, 1, D_BASE);
      #1;
      chk("stream_src", out_src, i % 4);
      chk("stream_data", out_data, 8'h10 + (i % 4));
      chk("stream_valid", out_valid, 1);
    end

    // Backpressure
    cycle(1, 4'b0000, 4'b1111, 1, D_BASE);
    cycle(0, 4'b1111, 4'b1111, 1, D_BASE);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'b1111, 4'b1111, 0, D_BASE);
      #1;
      chk("bp_data", out_data, 8'h10);
      chk("bp_src", out_src, 0);
      chk("bp_ready", req_ready, 0);
    end
    cycle(0, 4'b1111, 4'b1111, 1, D_BASE);
    #1;
    chk("bp_resume_valid", out_valid, 1);
    chk("bp_resume_src", out_src, 1);
    chk("bp_resume_data", out_data, 8'h11);

    // Pointer wrap
    cycle(1, 4'b0000, 4'b1111, 1, D_BASE);
    cycle(0, 4'b1000, 4'b1111, 1, D_BASE);
    #1; chk("wrap_src3", out_src, 3);
    cycle(0, 4'b0001, 4'b1111, 1, D_BASE);
    #1; chk("wrap_src0", out_src, 0);
    cycle(0, 4'b1111, 4'b1111, 1, D_BASE);
    #1; chk("wrap_ptr1", out_src, 1);

    // Reset mid-stream with a stalled beat
    cycle(0, 4'b1111, 4'b1111, 0, D_BASE);
    cycle(1, 4'b1111, 4'b1111, 0, D_BASE);
    #1;
    chk("midrst_valid", out_valid, 0);
    cycle(0, 4'b1111, 4'b1111, 1, D_BASE);
    #1;
    chk("midrst_src", out_src, 0);

    // Packet locking scenario: pointer primed to 1, then req0..2 valid, req1 ends on its third beat
`ifdef TAP_ARB_LOCK_EN
    exp_lock = '{1, 1, 1, 2, 0};
`else
    exp_lock = '{1, 2, 0, 1, 2};
`endif
    cycle(1, 4'b0000, 4'b1111, 1, D_BASE);
    cycle(0, 4'b0001, 4'b1111, 1, D_BASE);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'b0111, (i == 2) ? 4'b0111 : 4'b0101, 1, D_BASE);
      #1;
      chk("lock_src", out_src, exp_lock[i]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0), $urandom);
    end
    cycle(0, 4'b0000, 4'b1111, 1, D_BASE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
